// File: rtl/mp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mp_add_seq
//  Purpose  : Multi-precision add/subtract sequencer for an external WIDTH-bit
//             ripple-carry adder. Operand word pairs arrive least-significant
//             word first on a valid/ready stream. Each word is driven into the
//             adder for one cycle and carry-out is chained into the next word.
//             Result words leave on a valid/ready stream.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Configuration macro:
//    MPADD_OVF_EN - when defined, adds output out_ovf (signed overflow of the
//                   full operation, valid with out_last, 0 on other words).
// ----------------------------------------------------------------------------
//  Ports:
//    clk, rst              clock (rising edge), async active-high reset
//    in_valid/in_ready     operand stream handshake
//    in_a, in_b            operand word pair
//    op_sub                1 = A-B, 0 = A+B (sampled on word 0 only)
//    add_a, add_b, add_cin drive to the external adder (b pre-inverted for sub)
//    add_sum, add_cout     combinational result from the external adder
//    out_valid/out_ready   result stream handshake
//    out_sum               result word
//    out_last              result word is the final word of the operation
//    out_cout              final carry (subtract: 1 = no borrow), 0 unless last
//    out_ovf               (MPADD_OVF_EN only) signed overflow, 0 unless last
//    busy                  operation in progress or data held in the pipeline
// ============================================================================
module mp_add_seq #(
  parameter int WIDTH  = 64,
  parameter int NWORDS = 4,
  parameter int CNT_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             op_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout,
`ifdef MPADD_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // S1 operand register
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q, first_q, last_q, s1_valid;
  logic             carry_q;

  logic             adv;
  logic             accept;
  logic             word_first;
  logic             word_last;

  // S1 hands its word to S2 whenever S2 is empty or being drained this cycle.
  assign adv      = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | adv;
  assign accept   = in_valid & in_ready;

  assign add_a   = a_q;
  assign add_b   = sub_q ? ~b_q : b_q;
  // Word 0 seeds the chain with the op (+1 completes two's complement on sub);
  // later words take the carry of the previous word.
  assign add_cin = first_q ? sub_q : carry_q;

  assign busy = (state_q != IDLE) | s1_valid | out_valid;

  // --------------------------------------------------------------------------
  // Word-position FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_first = (state_q == IDLE);
    word_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_last = (NWORDS == 1);
          if (NWORDS > 1) begin
            state_d = RUN;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (cnt_q == LAST_CNT) begin
            word_last = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // S1 operand register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      s1_valid <= 1'b0;
    end else if (accept) begin
      a_q      <= in_a;
      b_q      <= in_b;
      first_q  <= word_first;
      last_q   <= word_last;
      s1_valid <= 1'b1;
      // op_sub only matters for word 0; later words reuse the latched op.
      if (word_first) begin
        sub_q <= op_sub;
      end
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // S2 output register and carry chain. carry_q only moves on adv, so a
  // stalled word never disturbs the carry its successor will consume.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      carry_q   <= 1'b0;
`ifdef MPADD_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_last  <= last_q;
      out_cout  <= last_q & add_cout;
      carry_q   <= add_cout;
`ifdef MPADD_OVF_EN
      // Carry into the MSB is a^b^sum at that bit; overflow when it differs
      // from carry out of the MSB.
      out_ovf   <= last_q &
                   (add_cout ^ (add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_sum[WIDTH-1]));
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mp_add_seq
//  Purpose  : Directed self-checking bench for mp_add_seq. Instance u0 uses
//             NWORDS=4, instance u1 uses NWORDS=1. Each has a behavioural
//             64-bit adder attached. With MPADD_OVF_EN defined, out_ovf is
//             connected and checked on u1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mp_add_seq;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- u0 : NWORDS = 4 ----------------
  logic        in_valid, in_ready, op_sub;
  logic [63:0] in_a, in_b;
  logic [63:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready, out_last, out_cout, busy;
  logic [63:0] out_sum;
`ifdef MPADD_OVF_EN
  logic        ovf0;
`endif

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

  mp_add_seq #(.WIDTH(64), .NWORDS(4), .CNT_W(2)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op_sub(op_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last), .out_cout(out_cout),
`ifdef MPADD_OVF_EN
    .out_ovf(ovf0),
`endif
    .busy(busy)
  );

  // ---------------- u1 : NWORDS = 1 ----------------
  logic        in_valid1, in_ready1, op_sub1;
  logic [63:0] in_a1, in_b1;
  logic [63:0] add_a1, add_b1, add_sum1;
  logic        add_cin1, add_cout1;
  logic        out_valid1, out_ready1, out_last1, out_cout1, busy1;
  logic [63:0] out_sum1;
`ifdef MPADD_OVF_EN
  logic        ovf1;
`endif

  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {64'd0, add_cin1};

  mp_add_seq #(.WIDTH(64), .NWORDS(1), .CNT_W(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .op_sub(op_sub1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_last(out_last1), .out_cout(out_cout1),
`ifdef MPADD_OVF_EN
    .out_ovf(ovf1),
`endif
    .busy(busy1)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [63:0] q_sum[$];
  logic        q_last[$];
  logic        q_cout[$];
  int          ncap = 0;

  logic [63:0] q1_sum[$];
  logic        q1_last[$];
  logic        q1_cout[$];
  logic        q1_ovf[$];
  int          ncap1 = 0;

  int cyc       = 0;
  int first_acc = -1;
  int first_ov  = -1;

  // Capture every consumed result word of both instances.
  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready && first_acc < 0) first_acc = cyc;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
        q_sum.push_back(out_sum);
        q_last.push_back(out_last);
        q_cout.push_back(out_cout);
        ncap = ncap + 1;
      end
      if (out_valid1 && out_ready1) begin
        q1_sum.push_back(out_sum1);
        q1_last.push_back(out_last1);
        q1_cout.push_back(out_cout1);
`ifdef MPADD_OVF_EN
        q1_ovf.push_back(ovf1);
`else
        q1_ovf.push_back(1'b0);
`endif
        ncap1 = ncap1 + 1;
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  // Present one operand word on u0 and hold it until accepted.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
    int   n;
    logic rdy;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    op_sub   = sub;
    n        = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    #1;
    in_valid = 1'b0;
    in_a     = 64'hDEAD_BEEF_0BAD_F00D;
    in_b     = 64'h0123_4567_89AB_CDEF;
    op_sub   = ~sub;
    if (!rdy) timeout("send");
  endtask

  task automatic wait_cap(input int target);
    int n;
    n = 0;
    while (ncap < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ncap < target) timeout("drain");
  endtask

  // Pop one captured u0 word and compare it.
  task automatic chk_word(input string tag, input logic [63:0] s, input logic l, input logic c);
    if (q_sum.size() == 0) begin
      timeout(tag);
    end else begin
      chk({tag, ".sum"},  q_sum.pop_front(), s);
      chk({tag, ".last"}, {63'd0, q_last.pop_front()}, {63'd0, l});
      chk({tag, ".cout"}, {63'd0, q_cout.pop_front()}, {63'd0, c});
    end
  endtask

  task automatic op1(input logic [63:0] a, input logic [63:0] b, input logic sub);
    int n;
    in_valid1 = 1'b1;
    in_a1     = a;
    in_b1     = b;
    op_sub1   = sub;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    n = 0;
    while (ncap1 == 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic chk_word1(input string tag, input logic [63:0] s, input logic c, input logic v);
    if (q1_sum.size() == 0) begin
      timeout(tag);
    end else begin
      chk({tag, ".sum"},  q1_sum.pop_front(), s);
      chk({tag, ".last"}, {63'd0, q1_last.pop_front()}, 64'd1);
      chk({tag, ".cout"}, {63'd0, q1_cout.pop_front()}, {63'd0, c});
`ifdef MPADD_OVF_EN
      chk({tag, ".ovf"},  {63'd0, q1_ovf.pop_front()}, {63'd0, v});
`else
      void'(q1_ovf.pop_front());
      if (v) begin end
`endif
      ncap1 = 0;
    end
  endtask

  int base;

  initial begin
    in_valid   = 1'b0; in_a  = '0; in_b  = '0; op_sub  = 1'b0; out_ready  = 1'b1;
    in_valid1  = 1'b0; in_a1 = '0; in_b1 = '0; op_sub1 = 1'b0; out_ready1 = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.out_sum",   out_sum, 64'd0);
    chk("rst.out_last",  {63'd0, out_last}, 64'd0);
    chk("rst.out_cout",  {63'd0, out_cout}, 64'd0);
    chk("rst.busy",      {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);

    // ---------------- test 1: all-ones + 1 ----------------
    send(ONES, 64'd1, 1'b0);
    send(ONES, 64'd0, 1'b0);
    send(ONES, 64'd0, 1'b0);
    send(ONES, 64'd0, 1'b0);
    wait_cap(4);
    chk("t1.latency", 64'(first_ov - first_acc), 64'd2);
    chk_word("t1.w0", 64'd0, 1'b0, 1'b0);
    chk_word("t1.w1", 64'd0, 1'b0, 1'b0);
    chk_word("t1.w2", 64'd0, 1'b0, 1'b0);
    chk_word("t1.w3", 64'd0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("t1.idle_busy", {63'd0, busy}, 64'd0);

    // ---------------- test 2: 0 - 1 (op_sub ignored after word 0) ----------------
    base = ncap;
    send(64'd0, 64'd1, 1'b1);
    send(64'd0, 64'd0, 1'b0);
    send(64'd0, 64'd0, 1'b0);
    send(64'd0, 64'd0, 1'b0);
    wait_cap(base + 4);
    chk_word("t2.w0", ONES, 1'b0, 1'b0);
    chk_word("t2.w1", ONES, 1'b0, 1'b0);
    chk_word("t2.w2", ONES, 1'b0, 1'b0);
    chk_word("t2.w3", ONES, 1'b1, 1'b0);

    // ---------------- test 3: backpressure after word 1 ----------------
    base = ncap;
    fork
      begin
        send(ONES, 64'd1, 1'b0);
        send(ONES, 64'd0, 1'b0);
        send(ONES, 64'd0, 1'b0);
        send(ONES, 64'd0, 1'b0);
      end
      begin
        int n;
        n = 0;
        while (ncap < base + 2 && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("t3.in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("t3.out_valid",    {63'd0, out_valid}, 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("t3.ncap_held",    64'(ncap - base), 64'd2);
        chk("t3.in_ready_hold", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
      end
    join
    wait_cap(base + 4);
    chk_word("t3.w0", 64'd0, 1'b0, 1'b0);
    chk_word("t3.w1", 64'd0, 1'b0, 1'b0);
    chk_word("t3.w2", 64'd0, 1'b0, 1'b0);
    chk_word("t3.w3", 64'd0, 1'b1, 1'b1);

    // ---------------- test 4: back-to-back, no carry leakage ----------------
    base = ncap;
    send(ONES, 64'd1, 1'b0);
    send(ONES, 64'd0, 1'b0);
    send(ONES, 64'd0, 1'b0);
    send(ONES, 64'd0, 1'b0);
    send(64'd0, 64'd0, 1'b0);
    send(64'd0, 64'd0, 1'b1);
    send(64'd0, 64'd0, 1'b1);
    send(64'd0, 64'd0, 1'b1);
    wait_cap(base + 8);
    chk_word("t4.a0", 64'd0, 1'b0, 1'b0);
    chk_word("t4.a1", 64'd0, 1'b0, 1'b0);
    chk_word("t4.a2", 64'd0, 1'b0, 1'b0);
    chk_word("t4.a3", 64'd0, 1'b1, 1'b1);
    chk_word("t4.b0", 64'd0, 1'b0, 1'b0);
    chk_word("t4.b1", 64'd0, 1'b0, 1'b0);
    chk_word("t4.b2", 64'd0, 1'b0, 1'b0);
    chk_word("t4.b3", 64'd0, 1'b1, 1'b0);

    // ---------------- test 5: async reset mid-operation ----------------
    send(ONES, 64'd1, 1'b0);
    send(ONES, 64'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5.out_valid", {63'd0, out_valid}, 64'd0);
    chk("t5.busy",      {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    q_sum.delete();
    q_last.delete();
    q_cout.delete();
    ncap = 0;
    @(posedge clk);
    #1;
    send(64'd1, 64'd1, 1'b0);
    send(64'd0, 64'd0, 1'b0);
    send(64'd0, 64'd0, 1'b0);
    send(64'd0, 64'd0, 1'b0);
    wait_cap(4);
    chk_word("t5.w0", 64'd2, 1'b0, 1'b0);
    chk_word("t5.w1", 64'd0, 1'b0, 1'b0);
    chk_word("t5.w2", 64'd0, 1'b0, 1'b0);
    chk_word("t5.w3", 64'd0, 1'b1, 1'b0);

    // ---------------- test 6: NWORDS = 1 instance ----------------
    op1(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    chk_word1("t6.maxpos", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    op1(64'd1, 64'd1, 1'b0);
    chk_word1("t6.one", 64'd2, 1'b0, 1'b0);
    op1(ONES, 64'd1, 1'b0);
    chk_word1("t6.wrap", 64'd0, 1'b1, 1'b0);
    op1(64'd5, 64'd3, 1'b1);
    chk_word1("t6.sub", 64'd2, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
